// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte-stream load request and instruction-memory write bundle
interface program_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a count-prefixed big-endian word stream into instruction memory
module program_loader #(
  parameter int ADDR_STEP = 4,
  parameter int MAX_WORDS = 64
) (
  input logic            clk,
  input logic            reset,
  program_loader_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] COUNT = 3'd1;
  localparam logic [2:0] BYTES = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        accept;
  logic [31:0] word_next;

  assign bus.byte_ready = (state_q == COUNT) || (state_q == BYTES);
  assign bus.mem_we     = (state_q == WRITE);
  assign bus.cpu_hold   = (state_q == COUNT) || (state_q == BYTES) || (state_q == WRITE);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

  assign accept    = bus.byte_valid && bus.byte_ready;
  assign word_next = {word_q[23:0], bus.byte_data};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d    = COUNT;
          done_d     = 1'b0;
          error_d    = 1'b0;
          word_idx_d = 8'd0;
          byte_cnt_d = 2'd0;
        end
      end
      COUNT: begin
        if (accept) begin
          count_d = bus.byte_data;
          if (bus.byte_data == 8'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (32'(bus.byte_data) > 32'(MAX_WORDS)) begin
            state_d = DONE;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            state_d = BYTES;
          end
        end
      end
      BYTES: begin
        if (accept) begin
          word_d     = word_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Address and data are registered here so they stay stable through WRITE and after.
          if (byte_cnt_q == 2'd3) begin
            state_d     = WRITE;
            mem_addr_d  = 8'(32'(word_idx_q) * ADDR_STEP);
            mem_wdata_d = word_next;
          end
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + 8'd1;
        if ((word_idx_q + 8'd1) < count_q) begin
          state_d = BYTES;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= 8'd0;
      word_idx_q  <= 8'd0;
      byte_cnt_q  <= 2'd0;
      word_q      <= 32'd0;
      mem_addr_q  <= 8'd0;
      mem_wdata_q <= 32'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized and directed bench for program_loader with a word-list model
module tb_program_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_loader_if bus();

  program_loader #(.ADDR_STEP(4), .MAX_WORDS(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [39:0] wr_q[$];
  logic [7:0]  stim_q[$];
  int  rdy_viol = 0;
  bit  mon_rdy = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
    if (mon_rdy && bus.cpu_hold === 1'b1 && (bus.byte_ready === bus.mem_we)) rdy_viol++;
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit rnd_start);
    int n;
    bus.byte_valid = 1'b0;
    repeat (gap) step();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    bus.start      = rnd_start ? 1'($urandom % 2) : 1'b0;
    n = 0;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("ready_timeout", 40'(bus.byte_ready), 40'd1);
    step();
    bus.byte_valid = 1'b0;
    bus.start      = 1'b0;
    bus.byte_data  = 8'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 40'(bus.byte_ready), 40'd0);
    check({tag, "_we"},    40'(bus.mem_we),     40'd0);
    check({tag, "_addr"},  40'(bus.mem_addr),   40'd0);
    check({tag, "_wdata"}, 40'(bus.mem_wdata),  40'd0);
    check({tag, "_hold"},  40'(bus.cpu_hold),   40'd0);
    check({tag, "_done"},  40'(bus.done),       40'd0);
    check({tag, "_error"}, 40'(bus.error),      40'd0);
  endtask

  // Expected writes come straight from the stream: word w is bytes 1+4w..4+4w at byte address 4w.
  task automatic run_load(input int gap_min, input int gap_max, input bit rnd_start);
    logic [39:0] exp_q[$];
    int n;
    int cnt;
    wr_q.delete();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("hold_after_start", 40'(bus.cpu_hold), 40'd1);
    check("done_cleared", 40'(bus.done), 40'd0);
    for (int i = 0; i < stim_q.size(); i++) begin
      send_byte(stim_q[i], $urandom_range(gap_max, gap_min), rnd_start);
      if (i > 0 && i % 4 == 0) check("we_latency", 40'(bus.mem_we), 40'd1);
    end
    n = 0;
    while (bus.done !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    cnt = int'(stim_q[0]);
    if (cnt == 0 || cnt > 64) check("done_latency", 40'(n), 40'd0);
    check("done", 40'(bus.done), 40'd1);
    check("hold_released", 40'(bus.cpu_hold), 40'd0);
    check("error", 40'(bus.error), 40'(cnt > 64));
    if (cnt >= 1 && cnt <= 64)
      for (int w = 0; w < cnt; w++)
        exp_q.push_back({8'(w * 4), stim_q[1 + 4 * w], stim_q[2 + 4 * w],
                         stim_q[3 + 4 * w], stim_q[4 + 4 * w]});
    check("n_writes", 40'(wr_q.size()), 40'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++)
      check($sformatf("write%0d", k), wr_q[k], exp_q[k]);
  endtask

  task automatic make_random(input int nwords);
    stim_q.delete();
    stim_q.push_back(8'(nwords));
    for (int i = 0; i < 4 * nwords; i++) stim_q.push_back(8'($urandom));
  endtask

  initial begin
    int sz;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();
    check_reset_outputs("idle");

    stim_q = '{8'h02, 8'hE3, 8'hA0, 8'h00, 8'h01, 8'hE2, 8'h81, 8'h10, 8'h02};
    run_load(0, 0, 1'b0);

    sz = wr_q.size();
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    repeat (3) step();
    bus.byte_valid = 1'b0;
    check("done_ignores_valid_writes", 40'(wr_q.size()), 40'(sz));
    check("done_ignores_valid_done", 40'(bus.done), 40'd1);

    stim_q = '{8'h00};
    run_load(0, 0, 1'b0);
    stim_q = '{8'h41};
    run_load(0, 0, 1'b0);
    stim_q = '{8'hC8};
    run_load(0, 2, 1'b1);

    make_random(1);
    rdy_viol = 0;
    mon_rdy = 1'b1;
    run_load(3, 3, 1'b0);
    mon_rdy = 1'b0;
    check("throttled_ready", 40'(rdy_viol), 40'd0);

    stim_q.delete();
    stim_q.push_back(8'd64);
    for (int w = 0; w < 64; w++) begin
      stim_q.push_back(8'(w >> 24)); stim_q.push_back(8'(w >> 16));
      stim_q.push_back(8'(w >> 8));  stim_q.push_back(8'(w));
    end
    run_load(0, 0, 1'b0);
    if (wr_q.size() > 0) check("last_addr", 40'(wr_q[wr_q.size() - 1][39:32]), 40'd252);

    for (int r = 0; r < 4; r++) begin
      make_random($urandom_range(8, 1));
      run_load(0, 2, 1'b1);
    end

    make_random(3);
    wr_q.delete();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(stim_q[i], 0, 1'b0);
    bus.start = 1'b1;
    bus.byte_valid = 1'b1;
    reset = 1'b1;
    step();
    check_reset_outputs("midload");
    reset = 1'b0;
    bus.start = 1'b0;
    repeat (4) step();
    bus.byte_valid = 1'b0;
    check("midload_no_write", 40'(wr_q.size()), 40'd0);
    check("midload_idle_hold", 40'(bus.cpu_hold), 40'd0);

    make_random(4);
    run_load(0, 1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter ADDR_STEP, default 4, meaning the byte-address increment between consecutive instruction words, matching the PC +4 step.
REQ-002 The block SHALL have parameter MAX_WORDS, default 64, meaning the largest legal word count (64 x 4 = 256 bytes, the full 8-bit address space).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to begin a load.
REQ-006 The block SHALL have port byte_valid, input, 1, meaning byte_data holds a valid byte.
REQ-007 The block SHALL have port byte_data, input, 8, the incoming stream byte.
REQ-008 The block SHALL have port byte_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-009 The block SHALL have port mem_we, output, 1, the instruction-memory write strobe.
REQ-010 The block SHALL have port mem_addr, output, 8, the instruction-memory byte address.
REQ-011 The block SHALL have port mem_wdata, output, 32, the instruction word to write.
REQ-012 The block SHALL have port cpu_hold, output, 1, which when high holds the PC and IF/ID enables low.
REQ-013 The block SHALL have port done, output, 1, a sticky flag meaning the load has completed.
REQ-014 The block SHALL have port error, output, 1, a sticky flag meaning the word count was illegal.

Function
REQ-015 A byte SHALL transfer only on a cycle where byte_valid and byte_ready are both high.
REQ-016 The FSM SHALL have states IDLE, COUNT, BYTES, WRITE and DONE.
REQ-017 In IDLE, start=1 SHALL move the FSM to COUNT, clear done and error, set cpu_hold=1, and zero the address and byte counters.
REQ-018 In COUNT, byte_ready SHALL be 1, and the first accepted byte SHALL be latched as the word count N.
REQ-019 From COUNT, N=0 SHALL go to DONE with no writes.
REQ-020 From COUNT, N>MAX_WORDS SHALL go to DONE with error=1 and no writes.
REQ-021 From COUNT, any other N SHALL go to BYTES.
REQ-022 In BYTES, byte_ready SHALL be 1, and bytes SHALL be assembled MSB-first: the first byte goes to word[31:24] and the fourth to word[7:0].
REQ-023 On the 4th accepted byte of a word, the FSM SHALL go to WRITE on the next edge.
REQ-024 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_addr = word_index x ADDR_STEP (8-bit) and mem_wdata = the assembled word.
REQ-025 In WRITE, byte_ready SHALL be 0.
REQ-026 From WRITE, the FSM SHALL return to BYTES if words written < N, else go to DONE.
REQ-027 Write latency SHALL be exactly one cycle from acceptance of a word's 4th byte to its mem_we pulse.
REQ-028 The minimum throughput SHALL be one word per 5 cycles.
REQ-029 In DONE, done SHALL be 1, cpu_hold SHALL be 0, and byte_ready SHALL be 0.
REQ-030 From DONE, start=1 SHALL begin a new load exactly as from IDLE.
REQ-031 start SHALL be ignored in COUNT, BYTES and WRITE.
REQ-032 byte_valid SHALL be ignored in IDLE, WRITE and DONE; no byte is consumed.
REQ-033 Gaps in byte_valid (byte_valid=0) SHALL stall assembly with no state change.
REQ-034 With N=64, the last write SHALL go to mem_addr=252; the address SHALL never wrap to 0 within a load.
REQ-035 mem_we SHALL never be high outside WRITE.
REQ-036 mem_addr and mem_wdata SHALL hold their last values outside WRITE.

Reset
REQ-037 When reset=1 at a clock edge, the block SHALL return to IDLE with byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0, all counters cleared.
REQ-038 Reset SHALL take priority over start and byte_valid, including mid-load: a partially assembled word SHALL be discarded and no further write issued.

Verification
REQ-039 Scenario, normal load: start; bytes 02, E3,A0,00,01, E2,81,10,02 -> mem_we at addr 0 with E3A00001 and at addr 4 with E2811002; then done=1, cpu_hold=0.
REQ-040 Scenario, zero count: start; byte 00 -> done=1 the next cycle, error=0, mem_we never asserted.
REQ-041 Scenario, illegal count: start; byte 41 (65) -> done=1, error=1, no writes.
REQ-042 Scenario, throttled stream: N=1 with byte_valid=0 for 3 cycles between bytes -> single write of the correct word; byte_ready=0 only during the WRITE cycle.
REQ-043 Scenario, full load: N=64 with incrementing words -> 64 writes at addresses 0..252 step 4, last address 252, no wrap.
REQ-044 Scenario, reset mid-load: reset asserted after 2 bytes of word 1 -> next cycle all outputs at reset values and no mem_we; a following start and full load succeeds.
